// File: rtl/mailbox.sv
// Receive mailbox: in-order message store with tag/wildcard selection; 1-cycle request-to-result latency.
// Backpressure: ready low when full (no bypass); requests stall until a match exists and no result is pending.
module mailbox #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       interface_mailbox_valid,
  output logic                       mailbox_interface_ready,
  input  logic [127:0]               interface_mailbox_data,
  input  logic                       receive_mailbox_valid,
  output logic                       mailbox_receive_ready,
  input  logic [31:0]                receive_mailbox_tag,
  input  logic                       receive_mailbox_any,
  output logic                       mailbox_result_valid,
  input  logic                       result_mailbox_ready,
  output logic [127:0]               mailbox_result_data,
  output logic [$clog2(DEPTH+1)-1:0] mailbox_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] tag;
  } msg_meta_t;

  typedef struct packed {
    msg_meta_t   meta;
    logic [63:0] data;
  } msg_t;

  msg_t            msg_q [DEPTH];
  msg_t            msg_d [DEPTH];
  logic [CW-1:0]   count_q, count_d;
  logic            rsv_vld_q, rsv_vld_d;
  logic [IW-1:0]   rsv_idx_q, rsv_idx_d;

  logic [DEPTH-1:0] match;
  logic             match_any;
  logic [IW-1:0]    sel_idx;
  logic             enq;
  logic             remove;
  logic             accept;
  logic [CW-1:0]    wr_idx;
  logic [CW-1:0]    enq_ext;
  logic [CW-1:0]    rem_ext;

  // Valid entries are the contiguous prefix [0, count), so validity is derived from count.
  always_comb begin
    match = '0;
    for (int k = 0; k < DEPTH; k++) begin
      match[k] = (CW'(k) < count_q)
               && !(rsv_vld_q && (rsv_idx_q == IW'(k)))
               && (receive_mailbox_any || (msg_q[k].meta.tag == receive_mailbox_tag));
    end
  end

  always_comb begin
    sel_idx = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match[k]) sel_idx = IW'(k);
    end
  end

  assign match_any               = |match;
  assign remove                  = rsv_vld_q & result_mailbox_ready & ~flush;
  assign mailbox_interface_ready = ~rst & (count_q < CW'(DEPTH));
  assign enq                     = interface_mailbox_valid & mailbox_interface_ready;
  assign mailbox_receive_ready   = receive_mailbox_valid & match_any & (~rsv_vld_q | remove)
                                 & ~flush & ~rst;
  assign accept                  = mailbox_receive_ready;

  assign enq_ext = {{(CW-1){1'b0}}, enq};
  assign rem_ext = {{(CW-1){1'b0}}, remove};
  assign wr_idx  = count_q - rem_ext;

  always_comb begin
    msg_d = msg_q;
    if (remove) begin
      for (int k = 0; k < DEPTH - 1; k++) begin
        if (IW'(k) >= rsv_idx_q) msg_d[k] = msg_q[k+1];
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (enq && (wr_idx == CW'(k))) msg_d[k] = interface_mailbox_data;
    end
  end

  // A new reservation taken in the removal cycle refers to pre-shift indices.
  always_comb begin
    count_d   = count_q + enq_ext - rem_ext;
    rsv_vld_d = rsv_vld_q;
    rsv_idx_d = rsv_idx_q;
    if (flush) begin
      rsv_vld_d = 1'b0;
    end else if (accept) begin
      rsv_vld_d = 1'b1;
      rsv_idx_d = (remove && (sel_idx > rsv_idx_q)) ? sel_idx - IW'(1) : sel_idx;
    end else if (remove) begin
      rsv_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      rsv_vld_q <= 1'b0;
      rsv_idx_q <= '0;
    end else begin
      count_q   <= count_d;
      rsv_vld_q <= rsv_vld_d;
      rsv_idx_q <= rsv_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < DEPTH; k++) begin
      msg_q[k] <= msg_d[k];
    end
  end

  assign mailbox_result_valid = rsv_vld_q;
  assign mailbox_result_data  = rsv_vld_q ? msg_q[rsv_idx_q] : '0;
  assign mailbox_count        = count_q;

endmodule

// File: tb/tb_mailbox.sv
// Bench for mailbox: directed vector tables, then random traffic against a queue-based reference.
module tb_mailbox;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [127:0] Z = '0;

  logic           clk = 1'b0;
  logic           rst, flush;
  logic           interface_mailbox_valid, mailbox_interface_ready;
  logic [127:0]   interface_mailbox_data;
  logic           receive_mailbox_valid, mailbox_receive_ready;
  logic [31:0]    receive_mailbox_tag;
  logic           receive_mailbox_any;
  logic           mailbox_result_valid, result_mailbox_ready;
  logic [127:0]   mailbox_result_data;
  logic [CW-1:0]  mailbox_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mailbox #(.DEPTH(DEPTH)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .flush                   (flush),
    .interface_mailbox_valid (interface_mailbox_valid),
    .mailbox_interface_ready (mailbox_interface_ready),
    .interface_mailbox_data  (interface_mailbox_data),
    .receive_mailbox_valid   (receive_mailbox_valid),
    .mailbox_receive_ready   (mailbox_receive_ready),
    .receive_mailbox_tag     (receive_mailbox_tag),
    .receive_mailbox_any     (receive_mailbox_any),
    .mailbox_result_valid    (mailbox_result_valid),
    .result_mailbox_ready    (result_mailbox_ready),
    .mailbox_result_data     (mailbox_result_data),
    .mailbox_count           (mailbox_count)
  );

  typedef struct {
    logic         in_v;
    logic [127:0] in_d;
    logic         rq_v;
    logic [31:0]  tag;
    logic         any;
    logic         fl;
    logic         rs;
    logic         rst;
    logic         e_ir;
    logic         e_rr;
    logic         e_rv;
    logic [127:0] e_rd;
    int           e_cnt;
  } vec_t;

  typedef struct {
    int           id;
    logic [127:0] m;
  } ent_t;

  function automatic logic [127:0] mk(input logic [31:0] t, input logic [63:0] d);
    return {32'hAD00_0000 ^ t, t, d};
  endfunction

  function automatic vec_t v(input int in_v, input logic [127:0] in_d, input int rq_v,
                             input logic [31:0] tag, input int any, input int fl, input int rs,
                             input int r, input int ir, input int rr, input int rv,
                             input logic [127:0] rd, input int cnt);
    vec_t t;
    t.in_v = (in_v != 0); t.in_d = in_d; t.rq_v = (rq_v != 0); t.tag = tag;
    t.any  = (any != 0);  t.fl   = (fl != 0); t.rs = (rs != 0); t.rst = (r != 0);
    t.e_ir = (ir != 0);   t.e_rr = (rr != 0); t.e_rv = (rv != 0); t.e_rd = rd; t.e_cnt = cnt;
    return t;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, compare outputs mid-cycle, then advance past the edge.
  task automatic apply(input vec_t t, input string name, input int idx);
    interface_mailbox_valid = t.in_v;
    interface_mailbox_data  = t.in_d;
    receive_mailbox_valid   = t.rq_v;
    receive_mailbox_tag     = t.tag;
    receive_mailbox_any     = t.any;
    flush                   = t.fl;
    result_mailbox_ready    = t.rs;
    rst                     = t.rst;
    @(negedge clk);
    chk($sformatf("%s[%0d].in_ready", name, idx), 128'(mailbox_interface_ready), 128'(t.e_ir));
    chk($sformatf("%s[%0d].rx_ready", name, idx), 128'(mailbox_receive_ready), 128'(t.e_rr));
    chk($sformatf("%s[%0d].res_valid", name, idx), 128'(mailbox_result_valid), 128'(t.e_rv));
    chk($sformatf("%s[%0d].res_data", name, idx), mailbox_result_data, t.e_rd);
    chk($sformatf("%s[%0d].count", name, idx), 128'(mailbox_count), 128'(t.e_cnt));
    @(posedge clk);
    #1;
  endtask

  ent_t q[$];
  int   rsv_id = -1;
  int   next_id = 0;

  vec_t fill_tbl[11];

  initial begin
    rst = 1'b1; flush = 1'b0;
    interface_mailbox_valid = 1'b0; interface_mailbox_data = Z;
    receive_mailbox_valid = 1'b0; receive_mailbox_tag = '0; receive_mailbox_any = 1'b0;
    result_mailbox_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    fill_tbl[0]  = v(1, mk(1, 64'h11), 0, 0, 0, 0, 0, 0,  1, 0, 0, Z, 0);
    fill_tbl[1]  = v(1, mk(2, 64'h22), 0, 0, 0, 0, 0, 0,  1, 0, 0, Z, 1);
    fill_tbl[2]  = v(1, mk(3, 64'h33), 0, 0, 0, 0, 0, 0,  1, 0, 0, Z, 2);
    fill_tbl[3]  = v(1, mk(4, 64'h44), 0, 0, 0, 0, 0, 0,  1, 0, 0, Z, 3);
    fill_tbl[4]  = v(1, mk(9, 64'h99), 0, 0, 0, 0, 0, 0,  0, 0, 0, Z, 4);
    fill_tbl[5]  = v(0, Z, 1, 0, 1, 0, 1, 0,  0, 1, 0, Z, 4);
    fill_tbl[6]  = v(0, Z, 1, 0, 1, 0, 1, 0,  0, 1, 1, mk(1, 64'h11), 4);
    fill_tbl[7]  = v(0, Z, 1, 0, 1, 0, 1, 0,  1, 1, 1, mk(2, 64'h22), 3);
    fill_tbl[8]  = v(0, Z, 1, 0, 1, 0, 1, 0,  1, 1, 1, mk(3, 64'h33), 2);
    fill_tbl[9]  = v(0, Z, 1, 0, 1, 0, 1, 0,  1, 0, 1, mk(4, 64'h44), 1);
    fill_tbl[10] = v(0, Z, 0, 0, 0, 0, 0, 0,  1, 0, 0, Z, 0);

    apply(v(0, Z, 1, 5, 1, 0, 0, 1,  0, 0, 0, Z, 0), "reset", 0);

    for (int i = 0; i < 11; i++) apply(fill_tbl[i], "fill_drain", i);

    // Tag selection with {5,7,5}
    apply(v(1, mk(5, 64'hA), 0, 0, 0, 0, 0, 0,  1, 0, 0, Z, 0), "tagsel", 0);
    apply(v(1, mk(7, 64'h7), 0, 0, 0, 0, 0, 0,  1, 0, 0, Z, 1), "tagsel", 1);
    apply(v(1, mk(5, 64'hB), 0, 0, 0, 0, 0, 0,  1, 0, 0, Z, 2), "tagsel", 2);
    apply(v(0, Z, 1, 5, 0, 0, 0, 0,  1, 1, 0, Z, 3), "tagsel", 3);
    apply(v(0, Z, 1, 5, 0, 0, 1, 0,  1, 1, 1, mk(5, 64'hA), 3), "tagsel", 4);
    apply(v(0, Z, 0, 0, 0, 0, 1, 0,  1, 0, 1, mk(5, 64'hB), 2), "tagsel", 5);
    apply(v(0, Z, 1, 7, 0, 0, 1, 0,  1, 1, 0, Z, 1), "tagsel", 6);
    apply(v(0, Z, 0, 0, 0, 0, 1, 0,  1, 0, 1, mk(7, 64'h7), 1), "tagsel", 7);
    apply(v(0, Z, 0, 0, 0, 0, 0, 0,  1, 0, 0, Z, 0), "tagsel", 8);

    // Blocking request
    apply(v(0, Z, 1, 9, 0, 0, 0, 0,  1, 0, 0, Z, 0), "blocking", 0);
    apply(v(1, mk(9, 64'hCAFE), 1, 9, 0, 0, 0, 0,  1, 0, 0, Z, 0), "blocking", 1);
    apply(v(0, Z, 1, 9, 0, 0, 0, 0,  1, 1, 0, Z, 1), "blocking", 2);
    apply(v(0, Z, 0, 0, 0, 0, 1, 0,  1, 0, 1, mk(9, 64'hCAFE), 1), "blocking", 3);
    apply(v(0, Z, 0, 0, 0, 0, 0, 0,  1, 0, 0, Z, 0), "blocking", 4);

    // Flush with a pending result
    apply(v(1, mk(3, 64'hF00D), 0, 0, 0, 0, 0, 0,  1, 0, 0, Z, 0), "flush", 0);
    apply(v(0, Z, 1, 3, 0, 0, 0, 0,  1, 1, 0, Z, 1), "flush", 1);
    apply(v(0, Z, 1, 3, 0, 1, 1, 0,  1, 0, 1, mk(3, 64'hF00D), 1), "flush", 2);
    apply(v(0, Z, 1, 3, 0, 0, 0, 0,  1, 1, 0, Z, 1), "flush", 3);
    apply(v(0, Z, 0, 0, 0, 0, 1, 0,  1, 0, 1, mk(3, 64'hF00D), 1), "flush", 4);
    apply(v(0, Z, 0, 0, 0, 0, 0, 0,  1, 0, 0, Z, 0), "flush", 5);

    // Full buffer with simultaneous enqueue attempt and removal
    for (int i = 0; i < 4; i++)
      apply(v(1, mk(11 + i, 64'(i)), 0, 0, 0, 0, 0, 0,  1, 0, 0, Z, i), "full_rm", i);
    apply(v(0, Z, 1, 0, 1, 0, 0, 0,  0, 1, 0, Z, 4), "full_rm", 4);
    apply(v(1, mk(15, 64'h5), 0, 0, 0, 0, 1, 0,  0, 0, 1, mk(11, 64'h0), 4), "full_rm", 5);
    apply(v(1, mk(15, 64'h5), 0, 0, 0, 0, 0, 0,  1, 0, 0, Z, 3), "full_rm", 6);
    apply(v(0, Z, 1, 0, 1, 0, 1, 0,  0, 1, 0, Z, 4), "full_rm", 7);
    apply(v(0, Z, 1, 0, 1, 0, 1, 0,  0, 1, 1, mk(12, 64'h1), 4), "full_rm", 8);
    apply(v(0, Z, 1, 0, 1, 0, 1, 0,  1, 1, 1, mk(13, 64'h2), 3), "full_rm", 9);
    apply(v(0, Z, 1, 0, 1, 0, 1, 0,  1, 1, 1, mk(14, 64'h3), 2), "full_rm", 10);
    apply(v(0, Z, 1, 0, 1, 0, 1, 0,  1, 0, 1, mk(15, 64'h5), 1), "full_rm", 11);
    apply(v(0, Z, 0, 0, 0, 0, 0, 0,  1, 0, 0, Z, 0), "full_rm", 12);

    // Reset mid-operation
    for (int i = 0; i < 3; i++)
      apply(v(1, mk(21 + i, 64'(i)), 0, 0, 0, 0, 0, 0,  1, 0, 0, Z, i), "rst_mid", i);
    apply(v(0, Z, 1, 0, 1, 0, 0, 0,  1, 1, 0, Z, 3), "rst_mid", 3);
    apply(v(1, mk(30, 64'h1), 1, 0, 1, 0, 0, 1,  0, 0, 1, mk(21, 64'h0), 3), "rst_mid", 4);
    apply(v(1, mk(30, 64'h1), 0, 0, 0, 0, 0, 1,  0, 0, 0, Z, 0), "rst_mid", 5);
    apply(v(0, Z, 0, 0, 0, 0, 0, 0,  1, 0, 0, Z, 0), "rst_mid", 6);

    // Random traffic against the reference queue (buffer is empty here)
    for (int n = 0; n < 2000; n++) begin
      vec_t t;
      int   rpos, sel;
      logic [31:0] etag;
      t.in_v = ($urandom_range(0, 1) == 1);
      etag   = 32'($urandom_range(1, 3));
      t.in_d = mk(etag, {$urandom, $urandom});
      t.rq_v = ($urandom_range(0, 3) != 0);
      t.tag  = 32'($urandom_range(1, 3));
      t.any  = ($urandom_range(0, 3) == 0);
      t.fl   = ($urandom_range(0, 15) == 0);
      t.rs   = ($urandom_range(0, 2) != 0);
      t.rst  = ($urandom_range(0, 199) == 0);

      rpos = -1;
      foreach (q[k]) if (q[k].id == rsv_id) rpos = k;
      sel = -1;
      foreach (q[k]) begin
        logic [127:0] m;
        m = q[k].m;
        if (sel < 0 && k != rpos && (t.any || m[95:64] == t.tag)) sel = k;
      end
      t.e_ir  = !t.rst && (q.size() < DEPTH);
      t.e_rv  = (rpos >= 0);
      t.e_rd  = (rpos >= 0) ? q[rpos].m : Z;
      t.e_cnt = q.size();
      t.e_rr  = t.rq_v && (sel >= 0) && ((rpos < 0) || (t.rs && !t.fl)) && !t.fl && !t.rst;

      apply(t, "random", n);

      if (t.rst) begin
        q.delete();
        rsv_id = -1;
      end else begin
        int new_rsv;
        new_rsv = rsv_id;
        if (t.e_rr) new_rsv = q[sel].id;
        else if (rpos >= 0 && t.rs && !t.fl) new_rsv = -1;
        if (rpos >= 0 && t.rs && !t.fl) q.delete(rpos);
        if (t.fl) new_rsv = -1;
        if (t.in_v && t.e_ir) begin
          ent_t e;
          e.id = next_id;
          e.m  = t.in_d;
          next_id++;
          q.push_back(e);
        end
        rsv_id = new_rsv;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mailbox.md
# mailbox

Receive-side message buffer sitting directly downstream of the bus communication interface. It accepts incoming messages (source address, tag, 64-bit payload) on a valid/ready handshake and stores them in arrival order. It serves blocking receive requests from the core pipeline: each request selects the oldest buffered message whose tag matches, or any message in wildcard mode. A selected message is removed only when its result is consumed, so a pipeline flush never loses a message.

## Interface
- DEPTH, default 4: number of message entries. Must be ≥ 2.
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  pipeline squash: cancels any outstanding reservation and result; buffered messages are kept
- interface_mailbox_valid  in  1  incoming message valid
- mailbox_interface_ready  out  1  buffer can accept a message
- interface_mailbox_data  in  128  interface_receive_data_t: message.meta.address[31:0], message.meta.tag[31:0], message.data[63:0]
- receive_mailbox_valid  in  1  core receive request valid
- mailbox_receive_ready  out  1  request accepted this cycle
- receive_mailbox_tag  in  32  requested tag
- receive_mailbox_any  in  1  1 = wildcard, match any tag
- mailbox_result_valid  out  1  result available
- result_mailbox_ready  in  1  consumer takes the result
- mailbox_result_data  out  128  selected message, interface_receive_data_t
- mailbox_count  out  $clog2(DEPTH+1)  number of occupied entries, including a reserved entry

## Operation
- Storage: entries 0..DEPTH-1, each holding {valid, reserved, message}. Entry 0 is the oldest. Valid entries are always contiguous from index 0.
- Enqueue fires when interface_mailbox_valid & mailbox_interface_ready. The message is written at index count, with any same-cycle removal taken into account (see Removal).
- mailbox_interface_ready = !rst & (count < DEPTH). There is no bypass: a full buffer keeps ready low even in a cycle where an entry is being removed.
- Match: entry k matches when valid & !reserved & (receive_mailbox_any | tag == receive_mailbox_tag). The selected entry is the lowest matching index.
- mailbox_receive_ready = receive_mailbox_valid & match exists & (no reservation, or the reservation is being released this cycle) & !flush & !rst.
- Accept (valid & ready): set reserved on the selected entry. Only one reservation may exist at a time.
- Result: mailbox_result_valid = a reserved entry exists. mailbox_result_data is that entry's message, and it stays stable while valid.
- Removal: when mailbox_result_valid & result_mailbox_ready, the reserved entry is cleared and every entry above it shifts down by one, preserving order.
- Flush: clear every reserved bit. No removal happens even if result_mailbox_ready is high. Enqueue proceeds normally. No request is accepted in a flush cycle.
- Blocking: a request with no match keeps ready low and waits. A message enqueued in cycle T becomes matchable from cycle T+1.
- Reset: all valid and reserved bits are cleared.

## Timing
- Reset values: mailbox_interface_ready 0 while rst is high and 1 afterwards; mailbox_receive_ready 0; mailbox_result_valid 0; mailbox_result_data 0; mailbox_count 0.
- Enqueue at T: count increments at T+1, and the entry is matchable at T+1.
- Request accepted at T: mailbox_result_valid = 1 at T+1, with data.
- Result consumed at U: the entry is gone and count decrements at U+1. A new request can be accepted in U, giving 1 result per cycle when consumed back-to-back.
- Enqueue and removal in the same cycle: count is unchanged. The new entry lands at the post-shift tail (index count-1).
- Full plus simultaneous removal: the enqueue is refused that cycle and ready rises at the next cycle.
- Flush at T with a result pending: mailbox_result_valid = 0 at T+1. The entry is still present and re-matchable from T+1.
- mailbox_count never exceeds DEPTH and never wraps.

## Test plan
- Fill and drain, DEPTH=4: enqueue tags 1,2,3,4 → ready=0, count=4. Four wildcard receives with ready held high → results 1,2,3,4 on consecutive cycles, then count=0.
- Tag selection: buffer holds tags {5,7,5}. Request tag 5 → result is entry 0. Request tag 5 again → result is the former entry 2. Tag 7 stays at index 0 and count=1.
- Blocking: request tag 9 on an empty buffer → ready stays 0. Enqueue tag 9 at T → request accepted at T+1, result valid at T+2 with the enqueued payload.
- Flush mid-result: accept a request for tag 3, hold result_mailbox_ready=0, assert flush → result_valid=0 next cycle, count unchanged. Re-request tag 3 → same payload returned.
- Simultaneous full enqueue/remove: full buffer, result consumed while interface_mailbox_valid=1 → message refused that cycle and accepted the next. Order is preserved.
- Reset mid-operation: assert rst with 3 entries and a pending result → next cycle count=0, result_valid=0. Ready stays 0 while rst is high and is 1 once rst drops.
